mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/def_mem_arb.sv | 18 +
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/arb_timer.sv | 31 +++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/def_mem_arb.sv
// Shared definitions for the memory arbiter: FSM state encodings, the default
// timeout length and a counter-width helper.
package def_mem_arb;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IM = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    localparam int WAIT_MAX_DEFAULT = 15;

    // Bits needed to count from 0 up to n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and shared memory port.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        err;
    logic        stall;

    modport slave (
        input  im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output im_ack, im_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               err, stall
    );

    modport master (
        output im_req, im_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  im_ack, im_rdata, dm_ack, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               err, stall
    );
endinterface

// File: rtl/arb_timer.sv
// Wait counter for one memory access: cleared on grant, counts busy cycles without
// mem_ready, and flags the cycle in which the count would reach WAIT_MAX.
module arb_timer
    import def_mem_arb::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_busy,
    input  logic i_ready,
    output logic o_timeout
);

    localparam int CW = cnt_width(WAIT_MAX);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_busy && !i_ready) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires on the WAIT_MAX-th stalled busy cycle so the FSM leaves on that edge.
    assign o_timeout = i_busy && !i_ready && (r_count == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter for a single shared memory port
// with timeout. Define MEM_ARB_RR_EN for round-robin tie breaking; default is fixed dm priority.
module mem_arbiter
    import def_mem_arb::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    arb_state_t  r_state;
    arb_state_t  w_state_next;
    logic        w_im_req;
    logic        w_dm_req;
    logic        w_pick_dm;
    logic        w_grant_im;
    logic        w_grant_dm;
    logic        w_busy;
    logic        w_timeout;
    logic        w_finish;

    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic        r_im_ack;
    logic        r_dm_ack;
    logic        r_err;
    logic [31:0] r_im_rdata;
    logic [31:0] r_dm_rdata;

    // A requester still holding req in its own ack cycle must not be granted again.
    assign w_im_req = bus.im_req & ~r_im_ack;
    assign w_dm_req = bus.dm_req & ~r_dm_ack;

`ifdef MEM_ARB_RR_EN
    logic r_prio_dm;
    logic w_tie;

    assign w_tie     = w_im_req & w_dm_req;
    assign w_pick_dm = w_dm_req & (~w_im_req | r_prio_dm);

    // Only a resolved tie moves the pointer: the winner yields the next tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prio_dm <= 1'b1;
        end else if (r_state == IDLE && w_tie) begin
            r_prio_dm <= ~w_pick_dm;
        end
    end
`else
    assign w_pick_dm = w_dm_req;
`endif

    always_comb begin
        w_state_next = r_state;
        w_grant_im   = 1'b0;
        w_grant_dm   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_dm) begin
                    w_state_next = BUSY_DM;
                    w_grant_dm   = 1'b1;
                end else if (w_im_req) begin
                    w_state_next = BUSY_IM;
                    w_grant_im   = 1'b1;
                end
            end
            BUSY_IM, BUSY_DM: begin
                if (bus.mem_ready || w_timeout) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_busy   = (r_state != IDLE);
    assign w_finish = w_busy && (bus.mem_ready || w_timeout);

    arb_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_grant_im | w_grant_dm),
        .i_busy    (w_busy),
        .i_ready   (bus.mem_ready),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_im_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_err      <= 1'b0;
            r_im_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_im_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            r_err    <= 1'b0;
            if (w_grant_dm) begin
                r_addr  <= bus.dm_addr;
                r_we    <= bus.dm_we;
                r_wdata <= bus.dm_wdata;
            end else if (w_grant_im) begin
                r_addr  <= bus.im_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
            end
            // A completing mem_ready takes precedence over a same-cycle timeout.
            if (w_finish) begin
                r_err <= ~bus.mem_ready;
                if (r_state == BUSY_IM) begin
                    r_im_ack   <= 1'b1;
                    r_im_rdata <= bus.mem_ready ? bus.mem_rdata : 32'd0;
                end else begin
                    r_dm_ack   <= 1'b1;
                    r_dm_rdata <= bus.mem_ready ? bus.mem_rdata : 32'd0;
                end
            end
        end
    end

    assign bus.mem_en    = w_busy;
    assign bus.mem_we    = w_busy & r_we;
    assign bus.mem_addr  = w_busy ? r_addr  : 32'd0;
    assign bus.mem_wdata = w_busy ? r_wdata : 32'd0;
    assign bus.im_ack    = r_im_ack;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.im_rdata  = r_im_rdata;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.err       = r_err;
    assign bus.stall     = (bus.im_req & ~r_im_ack) | (bus.dm_req & ~r_dm_ack);

endmodule
